parity_serial_tx: RTL and testbench
===================================

// Module: parity_serial_tx
// PURPOSE
//   Serial frame transmitter downstream of the parity generator and shift register.
//   Accepts an 8-bit word, computes even or odd parity, and shifts out one frame:
//   start(0), 8 data bits LSB-first, parity, stop(1).
//   Sits between the parallel datapath and the single-wire serial output.
// PARAMETERS
//   CLKS_PER_BIT  4  clk cycles each frame bit is held on tx_out (>=1)
// PORTS
//   clk          in   1  system clock; all state updates on posedge
//   reset        in   1  synchronous reset, active-high
//   data_in      in   8  word to transmit; sampled on accept
//   gen_odd_par  in   1  1 = odd parity, 0 = even parity; sampled on accept
//   start_valid  in   1  request to send data_in
//   ready        out  1  high only in IDLE; accept = start_valid & ready at posedge
//   tx_out       out  1  serial line; idles high
//   busy         out  1  high in any state other than IDLE
//   done         out  1  one-cycle pulse on the final cycle of the stop bit
// BEHAVIOUR
//   - Single clock domain (clk). Reset is synchronous and active-high (reset).
//   - Reset (sync, wins over all inputs): state=IDLE, tx_out=1, ready=1,
//     busy=0, done=0, counters=0. Mid-frame reset aborts the frame.
//     tx_out=1 from the next edge. No done pulse.
//   - Accept: at a posedge with start_valid=1 and ready=1, latch data_in into
//     shift_reg. Latch par = gen_odd_par ? ~^data_in : ^data_in.
//     start_valid while ready=0 is ignored (not queued).
//   - FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//     IDLE  : tx_out=1; accept -> START.
//     START : tx_out=0 for CLKS_PER_BIT cycles -> DATA.
//     DATA  : tx_out=shift_reg[0]; every CLKS_PER_BIT cycles shift right 1.
//             bit_cnt counts 0..7; after bit 7 -> PARITY.
//     PARITY: tx_out=par for CLKS_PER_BIT cycles -> STOP.
//     STOP  : tx_out=1 for CLKS_PER_BIT cycles; done=1 on last cycle -> IDLE.
//   - Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT+1).
//     It clears on every state change. bit_cnt is 3 bits and clears on entry to DATA.
//   - Latency: tx_out drops to 0 on the cycle after the accept edge.
//     A frame lasts exactly 11*CLKS_PER_BIT cycles; busy is high for all of them.
//   - Back-to-back: ready=1 on the cycle after done. That gives a minimum of
//     1 idle-high cycle between frames.
//   - tx_out, busy, ready and done are registered outputs: no combinational
//     path from any input.
//   - data_in and gen_odd_par changing mid-frame must not alter the frame.
// TESTING (CLKS_PER_BIT=4)
//   1. Assert reset for 2 cycles -> tx_out=1, ready=1, busy=0, done=0.
//   2. Send 0xA5, even parity -> tx_out sequence 0|1,0,1,0,0,1,0,1|0|1.
//      Each bit is 4 cycles. done pulses at cycle 44 after accept.
//   3. Send 0x00 with odd parity -> parity bit 1.
//      Send 0x01 with odd parity -> parity bit 0.
//      Send 0x01 with even parity -> parity bit 1.
//   4. Hold start_valid=1 with data 0xFF then 0x3C -> two frames.
//      Exactly 1 idle-high cycle between them. The 0x3C frame is not
//      corrupted by the data_in change during frame 1.
//   5. Assert reset during DATA bit 3 -> next cycle tx_out=1, ready=1, no done.
//      Then send 0x5A -> clean full frame.
//   6. Pulse start_valid while busy=1 -> ignored. Exactly one frame and one
//      done pulse are produced.

Source files
------------

// File: rtl/parity_serial_tx.sv
// -----------------------------------------------------------------------------
// parity_serial_tx
//   Serial frame transmitter. Accepts an 8-bit word together with a parity
//   mode and shifts out one frame on a single wire:
//     start(0), data[0..7] LSB-first, parity, stop(1)
//   Each frame bit is held for CLKS_PER_BIT clock cycles, so a frame lasts
//   11*CLKS_PER_BIT cycles.
//
// Parameters
//   CLKS_PER_BIT  clk cycles each frame bit is held on tx_out (>= 1)
//
// Ports
//   clk          in   system clock; all state updates on posedge
//   reset        in   synchronous reset, active-high; aborts any frame
//   data_in      in   [7:0] word to transmit; sampled on accept
//   gen_odd_par  in   1 = odd parity, 0 = even parity; sampled on accept
//   start_valid  in   request to send data_in; accept = start_valid & ready
//   ready        out  high only while idle
//   tx_out       out  serial line; idles high
//   busy         out  high whenever a frame is in progress
//   done         out  one-cycle pulse on the final cycle of the stop bit
// -----------------------------------------------------------------------------
module parity_serial_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       gen_odd_par,
  input  logic       start_valid,
  output logic       ready,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            r_state,  w_state_nxt;
  logic [BAUD_W-1:0] r_baud,   w_baud_nxt;
  logic [2:0]        r_bit,    w_bit_nxt;
  logic [7:0]        r_shift,  w_shift_nxt;
  logic              r_par,    w_par_nxt;

  // Output registers. Their next values are decoded from the *next* state so
  // that the registered outputs line up with the state they describe.
  logic r_tx_out, w_tx_nxt;
  logic r_busy,   w_busy_nxt;
  logic r_ready,  w_ready_nxt;
  logic r_done,   w_done_nxt;

  logic w_accept;
  logic w_baud_last;

  assign w_accept    = start_valid & r_ready;
  assign w_baud_last = (r_baud == BAUD_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
          w_baud_nxt  = '0;
          w_shift_nxt = data_in;
          w_par_nxt   = gen_odd_par ? ~^data_in : ^data_in;
        end
      end

      S_START: begin
        if (w_baud_last) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end

      S_DATA: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_PARITY;
          end else begin
            // Next data bit moves into shift_reg[0], which drives the line.
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      S_PARITY: begin
        if (w_baud_last) begin
          w_state_nxt = S_STOP;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end

      S_STOP: begin
        if (w_baud_last) begin
          w_state_nxt = S_IDLE;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
      end
    endcase

    // Output decode of the upcoming state.
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_done_nxt  = (w_state_nxt == S_STOP) && (w_baud_nxt == BAUD_LAST);

    unique case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
      default:  w_tx_nxt = 1'b1;   // IDLE and STOP hold the line high
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tx_out <= 1'b1;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_par    <= w_par_nxt;
      r_tx_out <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
      r_ready  <= w_ready_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign tx_out = r_tx_out;
  assign busy   = r_busy;
  assign ready  = r_ready;
  assign done   = r_done;

endmodule

// File: tb/tb_parity_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_parity_serial_tx
//   Self-checking bench for parity_serial_tx (CLKS_PER_BIT = 4). Expected
//   line levels come from a frame model: an 11-entry bit list built from the
//   word and parity rule, each entry held for CLKS_PER_BIT cycles.
//   Inputs change #1 after posedge or on negedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_parity_serial_tx;

  localparam int C     = 4;
  localparam int FRAME = 11 * C;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       gen_odd_par;
  logic       start_valid;
  logic       ready;
  logic       tx_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  parity_serial_tx #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .gen_odd_par (gen_odd_par),
    .start_valid (start_valid),
    .ready       (ready),
    .tx_out      (tx_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Parity rule from counting ones: even parity makes the total count even,
  // odd parity makes it odd.
  function automatic bit model_parity(input logic [7:0] d, input bit odd);
    int ones = $countones(d);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // Checks the FRAME cycles that follow an accept edge. With noise set, the
  // inputs are scrambled (including start_valid pulses) on every cycle.
  task automatic expect_frame(input string name, input logic [7:0] d, input bit odd,
                              input bit noise);
    bit bits [11];
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = d[k];
    bits[9]  = model_parity(d, odd);
    bits[10] = 1'b1;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      check($sformatf("%s tx c%0d", name, i), tx_out, bits[(i-1)/C]);
      check($sformatf("%s busy c%0d", name, i), busy, 1'b1);
      check($sformatf("%s ready c%0d", name, i), ready, 1'b0);
      check($sformatf("%s done c%0d", name, i), done, (i == FRAME));
      if (noise) begin
        data_in     = 8'($urandom);
        gen_odd_par = 1'($urandom);
        start_valid = (i < FRAME) ? 1'($urandom) : 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check($sformatf("%s tx", name), tx_out, 1'b1);
      check($sformatf("%s busy", name), busy, 1'b0);
      check($sformatf("%s ready", name), ready, 1'b1);
      check($sformatf("%s done", name), done, 1'b0);
    end
  endtask

  // Presents a request, takes the accept edge, then scrambles the inputs so a
  // frame that re-samples them mid-flight would show up as a wrong bit.
  task automatic send(input string name, input logic [7:0] d, input bit odd, input bit noise);
    @(posedge clk); #1;
    data_in     = d;
    gen_odd_par = odd;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    data_in     = ~d;
    gen_odd_par = ~odd;
    expect_frame(name, d, odd, noise);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    data_in     = 8'h00;
    gen_odd_par = 1'b0;
    start_valid = 1'b1;   // must be ignored while in reset

    // 1. Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst tx", tx_out, 1'b1);
    check("rst ready", ready, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    reset       = 1'b0;
    start_valid = 1'b0;
    check_idle("post_rst", 2);

    // 2. 0xA5, even parity.
    send("a5_even", 8'hA5, 1'b0, 1'b0);
    check_idle("after_a5", 1);

    // 3. Parity corner cases.
    send("00_odd", 8'h00, 1'b1, 1'b0);
    send("01_odd", 8'h01, 1'b1, 1'b0);
    send("01_even", 8'h01, 1'b0, 1'b0);
    check_idle("after_par", 1);

    // 4. start_valid held high: 0xFF then 0x3C, exactly one idle cycle.
    @(posedge clk); #1;
    data_in     = 8'hFF;
    gen_odd_par = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    data_in     = 8'h3C;
    gen_odd_par = 1'b1;
    expect_frame("ff", 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b gap tx", tx_out, 1'b1);
    check("b2b gap ready", ready, 1'b1);
    check("b2b gap busy", busy, 1'b0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    expect_frame("3c", 8'h3C, 1'b1, 1'b0);
    check_idle("after_3c", 2);

    // 5. Reset during DATA bit 3 (frame cycles 17..20).
    @(posedge clk); #1;
    data_in     = 8'hC3;
    gen_odd_par = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (18) @(negedge clk);
    check("mid bit3 tx", tx_out, 1'b0);   // 0xC3 bit 3 = 0
    check("mid busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("abort tx", tx_out, 1'b1);
    check("abort ready", ready, 1'b1);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    reset = 1'b0;
    check_idle("after_abort", FRAME);
    send("5a", 8'h5A, 1'b0, 1'b0);
    check_idle("after_5a", 1);

    // 6. start_valid pulses while busy are ignored.
    send("noise", 8'h96, 1'b1, 1'b1);
    check_idle("after_noise", 2 * C);

    // Randomized frames.
    for (int n = 0; n < 8; n++) begin
      logic [7:0] d;
      bit         o;
      d = 8'($urandom);
      o = 1'($urandom);
      send($sformatf("rnd%0d", n), d, o, 1'($urandom));
      check_idle($sformatf("rnd_idle%0d", n), 1 + $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
